// File: rtl/rbr_pkg.sv
// Shared types for the redundant-binary online datapath: signed digits and the
// on-the-fly converter state encoding.
package rbr_pkg;

  typedef struct packed {
    logic plus;
    logic minus;
  } signed_digit;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } otf_state_t;

  // {0,0} and {1,1} both encode zero
  function automatic logic signed [1:0] sd_value(signed_digit d);
    case ({d.plus, d.minus})
      2'b10:   return 2'sd1;
      2'b01:   return -2'sd1;
      default: return 2'sd0;
    endcase
  endfunction

endpackage

// File: rtl/otf_append.sv
// One on-the-fly conversion step: appends digit d to the Q / QM (= Q - ulp) pair.
module otf_append
  import rbr_pkg::*;
#(
  parameter int W = 33
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  signed_digit  d,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  logic signed [1:0] v;

  always_comb begin
    v       = sd_value(d);
    q_next  = {q[W-2:0], 1'b0};
    qm_next = {qm[W-2:0], 1'b1};
    if (v == 2'sd1) begin
      q_next  = {q[W-2:0], 1'b1};
      qm_next = {q[W-2:0], 1'b0};
    end else if (v == -2'sd1) begin
      q_next  = {qm[W-2:0], 1'b1};
      qm_next = {qm[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/online_otf_convert.sv
// On-the-fly converter: signed-digit MSD-first stream -> two's-complement fraction.
// Optional macro OTF_PROTOCOL_CHECK_EN enables the sticky err flag (nonzero digit in SKIP).
module online_otf_convert
  import rbr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DELAY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  signed_digit      z,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             err
);

  localparam int CMAX = (WIDTH > DELAY) ? WIDTH : DELAY;
  localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);
  localparam logic [CW-1:0] LAST_SKIP = CW'(DELAY - 1);
  localparam logic [CW-1:0] LAST_CONV = CW'(WIDTH - 1);
  localparam otf_state_t    FIRST_ST  = (DELAY == 0) ? CONVERT : SKIP;

  otf_state_t    state;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] q_r, qm_r, q_nx, qm_nx;
  logic          launch;

  otf_append #(.W(WIDTH + 1)) u_append (
    .q       (q_r),
    .qm      (qm_r),
    .d       (z),
    .q_next  (q_nx),
    .qm_next (qm_nx)
  );

  // a restart is honoured from IDLE, or from DONE only together with acceptance
  assign launch = en && start && ((state == IDLE) || ((state == DONE) && out_ready));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      q_r    <= '0;
      qm_r   <= '1;
      result <= '0;
    end else if (launch) begin
      state <= FIRST_ST;
      cnt   <= '0;
      q_r   <= '0;
      qm_r  <= '1;
    end else begin
      case (state)
        SKIP: if (en) begin
          if (cnt == LAST_SKIP) begin
            state <= CONVERT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CONVERT: if (en) begin
          q_r  <= q_nx;
          qm_r <= qm_nx;
          if (cnt == LAST_CONV) begin
            state  <= DONE;
            result <= q_nx;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

`ifdef OTF_PROTOCOL_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      err <= 1'b0;
    else if ((state == SKIP) && en && (sd_value(z) != 2'sd0))
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_online_otf_convert.sv
// Scoreboard bench for online_otf_convert (WIDTH=8, DELAY=3).
module tb_online_otf_convert;
  import rbr_pkg::*;

  localparam int WIDTH = 8;
  localparam int DELAY = 3;
`ifdef OTF_PROTOCOL_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n, en, start, out_ready;
  signed_digit     z;
  logic            busy, out_valid, err;
  logic [WIDTH:0]  result;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] exp_q[$];

  online_otf_convert #(.WIDTH(WIDTH), .DELAY(DELAY)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .start     (start),
    .z         (z),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every accepted result is popped and compared against the scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", result);
      end else begin
        chk("result", 32'(result), 32'(exp_q.pop_front()));
      end
    end
  end

  // digits are 2-bit {plus,minus} codes, first-sampled digit in the top bits
  task automatic run(input logic [5:0] sk, input logic [15:0] dg, input logic [WIDTH:0] exp,
                     input int gap, input bit xstart, input logic rdy);
    @(posedge clk); #1;
    start = 1'b1; en = 1'b1; z = '0; out_ready = rdy;
    exp_q.push_back(exp);
    for (int s = 0; s < DELAY; s++) begin
      @(posedge clk); #1;
      start = 1'b0;
      z = signed_digit'(sk[2*(DELAY-1-s) +: 2]);
      if (s == 0) begin
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("ovalid_low_after_start", 32'(out_valid), 32'd0);
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      @(posedge clk); #1;
      if (i == 4 && gap > 0) begin
        en = 1'b0;
        z = signed_digit'(2'b10);
        repeat (gap) begin @(posedge clk); #1; end
        en = 1'b1;
      end
      start = (xstart && i == 2);
      z = signed_digit'(dg[2*(WIDTH-1-i) +: 2]);
    end
    chk("ovalid_not_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; z = '0;
    chk("ovalid_latency", 32'(out_valid), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; start = 1'b0; z = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    run(6'b0, 16'h8000, 9'h080, 0, 0, 1'b1);   // 0.5
    run(6'b0, 16'h5555, 9'h101, 0, 0, 1'b1);   // -255/256
    run(6'b0, 16'hAAAA, 9'h0FF, 0, 0, 1'b1);   // +255/256
    run(6'b0, 16'h9002, 9'h041, 0, 0, 1'b1);   // 1/2 - 1/4 + 1/256
    run(6'b0, 16'h1800, 9'h1E0, 0, 0, 1'b1);   // -1/4 + 1/8
    run(6'b0, 16'h1000, 9'h1C0, 0, 0, 1'b1);   // -1/4
    run(6'b0, 16'h9002, 9'h041, 3, 1, 1'b1);   // en gap + stray start
    chk("err_clean", 32'(err), 32'd0);

    run(6'b10_00_00, 16'hAAAA, 9'h0FF, 0, 0, 1'b1);
    chk("err_skip_digit", 32'(err), 32'(ERR_EXP));

    run(6'b0, 16'h2000, 9'h040, 0, 0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_ovalid", 32'(out_valid), 32'd1);
      chk("hold_result", 32'(result), 32'h040);
    end
    run(6'b0, 16'h5555, 9'h101, 0, 0, 1'b1);   // accept + restart together
    chk("err_sticky", 32'(err), 32'(ERR_EXP));

    @(posedge clk); #1;
    start = 1'b1; en = 1'b1; z = '0;
    repeat (DELAY + 3) begin
      @(posedge clk); #1;
      start = 1'b0; z = signed_digit'(2'b10);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; z = '0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ovalid", 32'(out_valid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);

    run(6'b0, 16'h8000, 9'h080, 0, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
